if_fetch_unit: RTL

Instruction-fetch front end of the mips_16 pipeline: the producer side of the IF/ID interface. It issues word reads to instruction memory over a request/grant/response port and buffers the returned words with their PCs in a prefetch queue. It presents one instruction per cycle to the decode stage and redirects the PC when decode resolves a taken branch. Empty or squashed slots are delivered as NOP (16'h0000) bubbles.

---
 rtl/if_fetch_unit_pkg.sv | 7 +
 rtl/if_fetch_unit_fifo.sv | 56 +++++
 rtl/if_fetch_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared instruction-fetch definitions: imem word width and the NOP bubble encoding.
package if_fetch_unit_pkg;

    localparam int unsigned IMEM_WIDTH = 16;
    localparam logic [IMEM_WIDTH-1:0] OP_NOP = '0;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Prefetch queue: DEPTH x WIDTH synchronous FIFO with clear, count, empty and full.
module if_prefetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

    // The issue limit keeps queued plus in-flight words within DEPTH.
    push_while_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !clear));

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: issues imem word reads, queues {pc, word}, feeds decode, redirects on taken branch.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned          PC_WIDTH = 8,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instruction_fetch_en,
    input  logic                  branch_taken,
    input  logic [5:0]            branch_offset_imm,
    output logic [15:0]           instruction,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [15:0]           imem_rdata,
    output logic                  fetch_empty
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned EW = PC_WIDTH + IMEM_WIDTH;

    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] resp_pc;
    logic [PC_WIDTH-1:0] id_pc;
    logic [PC_WIDTH-1:0] target;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       outstanding_next;
    logic [CW-1:0]       discard;
    logic [CW-1:0]       count;
    logic [CW:0]         in_use;
    logic [EW-1:0]       head;
    logic                empty;
    logic                full;
    logic                redirect;
    logic                grant;
    logic                push;
    logic                pop;

    assign redirect    = branch_taken & instruction_fetch_en;
    assign pop         = instruction_fetch_en & ~empty & ~redirect;
    assign push        = imem_rvalid & (discard == '0);
    assign in_use      = {1'b0, count} + {1'b0, outstanding};
    assign imem_req    = rst_n & ~redirect & (in_use < (CW+1)'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req & imem_gnt;
    assign instruction = (empty | redirect) ? OP_NOP : head[IMEM_WIDTH-1:0];
    assign fetch_empty = empty;
    assign target      = id_pc + PC_WIDTH'(1) + PC_WIDTH'(signed'(branch_offset_imm));

    assign outstanding_next = outstanding + CW'(grant) - CW'(imem_rvalid);

    if_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata ({resp_pc, imem_rdata}),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            id_pc       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (instruction_fetch_en) id_pc <= head[EW-1:IMEM_WIDTH];
            // Every word still in flight after this edge belongs to the squashed stream.
            if (redirect) begin
                fetch_pc <= target;
                resp_pc  <= target;
                discard  <= outstanding_next;
            end else begin
                if (grant) fetch_pc <= fetch_pc + PC_WIDTH'(1);
                if (push)  resp_pc  <= resp_pc + PC_WIDTH'(1);
                if (imem_rvalid && discard != '0) discard <= discard - CW'(1);
            end
        end
    end

endmodule
